// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED decoder: width codes, FSM states and
// width/data-bit lookups used by the decoder core and the data extractor.
package ecc_pkg;

  localparam logic [1:0] CW_8  = 2'b00;
  localparam logic [1:0] CW_16 = 2'b01;
  localparam logic [1:0] CW_32 = 2'b10;

  localparam int DBITS_8  = 4;
  localparam int DBITS_16 = 11;
  localparam int DBITS_32 = 26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CORRECT,
    ST_DONE
  } state_t;

  // Codeword width W for a width code; 2'b11 aliases to 32 bits.
  function automatic logic [5:0] cw_bits(input logic [1:0] code);
    case (code)
      CW_8:    return 6'd8;
      CW_16:   return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic int data_bits(input logic [1:0] code);
    case (code)
      CW_8:    return DBITS_8;
      CW_16:   return DBITS_16;
      default: return DBITS_32;
    endcase
  endfunction

  function automatic logic is_pow2(input logic [5:0] p);
    return (p != 6'd0) && ((p & (p - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/ecc_data_extract.sv
// Packs the non-parity Hamming positions of a W-bit codeword into an
// LSB-first data word; the overall parity bit cw[W-1] is never data.
module ecc_data_extract
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [AMBA_WORD-1:0]  cw,
  input  logic [1:0]            cw_width,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int KW = $clog2(DATA_WIDTH);

  logic [5:0]    lim;
  logic [KW-1:0] k;

  assign lim = cw_bits(cw_width) - 6'd1;

  always_comb begin
    data = '0;
    k    = '0;
    for (int i = 0; i < AMBA_WORD - 1; i++) begin
      if ((6'(i) < lim) && !is_pow2(6'(i + 1))) begin
        data[k] = cw[i];
        k       = k + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecc_dec_core.sv
// Serial SECDED decoder: scans one codeword bit per cycle to build syndrome
// and overall parity, then corrects/flags. Single-bit correction is enabled
// by defining ECC_DEC_CORRECT_EN; otherwise the block is detect-only.
module ecc_dec_core
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int AMBA_WORD  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cw_width,
  input  logic [AMBA_WORD-1:0]  codeword_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors
);

  state_t state_q, state_d;

  logic [AMBA_WORD-1:0]  cw_q;
  logic [1:0]            wcode_q;
  logic [5:0]            w_q;
  logic [4:0]            idx_q;
  logic [4:0]            syn_q;
  logic                  par_q;

  logic                  cur_bit;
  logic                  last;
  logic [AMBA_WORD-1:0]  cw_fix;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [1:0]            err_d;

  assign cur_bit = cw_q[idx_q];
  assign last    = ({1'b0, idx_q} == (w_q - 6'd1));

  // Handshake: start is a request pulse, honoured only when busy is low;
  // done pulses for exactly one cycle with data_out/num_of_errors valid.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SCAN;
      ST_SCAN:    if (last) state_d = ST_CORRECT;
      ST_CORRECT: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  // A syndrome with odd overall parity points at the flipped position;
  // syndrome 0 with odd parity means only the overall bit was hit.
  always_comb begin
    cw_fix = cw_q;
`ifdef ECC_DEC_CORRECT_EN
    if (par_q && (syn_q != 5'd0)) cw_fix[syn_q - 5'd1] = ~cw_q[syn_q - 5'd1];
`endif
  end

  always_comb begin
    err_d = 2'd0;
    if (par_q)                err_d = 2'd1;
    else if (syn_q != 5'd0)   err_d = 2'd2;
  end

  ecc_data_extract #(
    .AMBA_WORD (AMBA_WORD),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extract (
    .cw      (cw_fix),
    .cw_width(wcode_q),
    .data    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cw_q          <= '0;
      wcode_q       <= '0;
      w_q           <= 6'd0;
      idx_q         <= 5'd0;
      syn_q         <= 5'd0;
      par_q         <= 1'b0;
      data_out      <= '0;
      num_of_errors <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cw_q    <= codeword_in;
            wcode_q <= cw_width;
            w_q     <= cw_bits(cw_width);
            idx_q   <= 5'd0;
            syn_q   <= 5'd0;
            par_q   <= 1'b0;
          end
        end
        ST_SCAN: begin
          par_q <= par_q ^ cur_bit;
          // The overall parity bit contributes to parity only, not syndrome.
          if (!last && cur_bit) syn_q <= syn_q ^ (idx_q + 5'd1);
          if (!last) idx_q <= idx_q + 5'd1;
        end
        ST_CORRECT: begin
          data_out      <= ext_data;
          num_of_errors <= err_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_dec_core.sv
// Directed bench for ecc_dec_core: clean, single, overall-bit and double
// errors, width aliasing, start-while-busy, reset abort and back-to-back.
module tb_ecc_dec_core;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  cw_width;
  logic [31:0] codeword_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;

  int n_vec;
  int n_err;

  ecc_dec_core #(.DATA_WIDTH(32), .AMBA_WORD(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cw_width     (cw_width),
    .codeword_in  (codeword_in),
    .busy         (busy),
    .done         (done),
    .data_out     (data_out),
    .num_of_errors(num_of_errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full operation; restart=1 pulses start again around E5 while busy.
  task automatic do_op(input string name, input logic [1:0] wc, input logic [31:0] cw,
                       input logic [31:0] exp_d, input logic [1:0] exp_e, input bit restart);
    int exp_lat;
    int got;
    exp_lat = (wc == 2'b00) ? 9 : (wc == 2'b01) ? 17 : 33;
    got = 0;
    start = 1'b1;
    cw_width = wc;
    codeword_in = cw;
    @(posedge clk); #1;
    start = 1'b0;
    codeword_in = ~cw;
    cw_width = ~wc;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_after_e0: got %b want 1", name, busy);
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (restart && n == 4) begin
        start = 1'b1;
        codeword_in = 32'hFFFF_FFFF;
      end
      if (n == 5) start = 1'b0;
      if (done === 1'b1) begin
        got = n;
        break;
      end
    end
    n_vec++;
    if (got != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, got, exp_lat);
    end
    n_vec++;
    if (data_out !== exp_d) begin
      n_err++;
      $display("FAIL %s data_out: got %h want %h", name, data_out, exp_d);
    end
    n_vec++;
    if (num_of_errors !== exp_e) begin
      n_err++;
      $display("FAIL %s num_of_errors: got %0d want %0d", name, num_of_errors, exp_e);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0/0", name, done, busy);
    end
    if (restart) begin
      // Any accepted second start would make busy/done reappear here.
      got = 0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk); #1;
        if (done === 1'b1 || busy === 1'b1) got++;
      end
      n_vec++;
      if (got != 0) begin
        n_err++;
        $display("FAIL %s ignored_restart: got %0d busy/done cycles want 0", name, got);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    cw_width = 2'b00;
    codeword_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0 || num_of_errors !== 2'd0) begin
      n_err++;
      $display("FAIL reset_values: got busy=%b done=%b data=%h err=%0d want 0/0/0/0",
               busy, done, data_out, num_of_errors);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_width8;
    do_op("clean8", 2'b00, 32'h0000_0055, 32'hB, 2'd0, 0);
`ifdef ECC_DEC_CORRECT_EN
    do_op("single8", 2'b00, 32'h0000_0045, 32'hB, 2'd1, 0);
`else
    do_op("single8", 2'b00, 32'h0000_0045, 32'h9, 2'd1, 0);
`endif
    do_op("overall8", 2'b00, 32'h0000_00D5, 32'hB, 2'd1, 0);
    do_op("double8", 2'b00, 32'h0000_0044, 32'h9, 2'd2, 0);
    do_op("upper_ignored8", 2'b00, 32'hFFFF_FF55, 32'hB, 2'd0, 0);
  endtask

  task automatic test_wide;
    do_op("clean16", 2'b01, 32'h0000_8007, 32'h1, 2'd0, 0);
`ifdef ECC_DEC_CORRECT_EN
    do_op("single16", 2'b01, 32'h0000_0004, 32'h0, 2'd1, 0);
`else
    do_op("single16", 2'b01, 32'h0000_0004, 32'h1, 2'd1, 0);
`endif
    do_op("double32", 2'b10, 32'h0000_0003, 32'h0, 2'd2, 0);
    do_op("code11_restart", 2'b11, 32'h0000_0000, 32'h0, 2'd0, 1);
  endtask

  task automatic test_reset_abort;
    int seen;
    do_op("pre_abort", 2'b00, 32'h0000_0055, 32'hB, 2'd0, 0);
    start = 1'b1;
    cw_width = 2'b00;
    codeword_in = 32'h0000_0045;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || data_out !== 32'h0 || num_of_errors !== 2'd0) begin
      n_err++;
      $display("FAIL abort_state: got busy=%b data=%h err=%0d want 0/0/0",
               busy, data_out, num_of_errors);
    end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
    end
    do_op("post_abort", 2'b00, 32'h0000_00D5, 32'hB, 2'd1, 0);
  endtask

  // Each op returns right after the edge leaving DONE, so the next start
  // is sampled on the very next edge with no idle gap.
  task automatic test_back_to_back;
    do_op("b2b_a", 2'b00, 32'h0000_0055, 32'hB, 2'd0, 0);
    do_op("b2b_b", 2'b00, 32'h0000_0044, 32'h9, 2'd2, 0);
    do_op("b2b_c", 2'b01, 32'h0000_8007, 32'h1, 2'd0, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_width8();
    test_wide();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecc_dec_core.md
# ecc_dec_core

Multi-cycle SECDED (extended Hamming) decoder sitting directly downstream of the APB register stage in the ECC encoder/decoder design. Accepts a codeword and width code from the control path on a start pulse and scans it serially to build syndrome and overall parity. Then corrects a single-bit error or flags a double error, and presents extracted data plus error count with a one-cycle done pulse.

## Interface
- DATA_WIDTH, 32: width of data_out; extracted data is zero-extended into it.
- AMBA_WORD, 32: width of codeword_in; maximum codeword is 32 bits.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- start  input  1  request pulse; sampled only in IDLE.
- cw_width  input  2  codeword width code: 00 = 8 bits, 01 = 16 bits, 10 and 11 = 32 bits.
- codeword_in  input  AMBA_WORD  received codeword, LSB-aligned; bits at index W and above are ignored.
- busy  output  1  high while an operation is in flight, including the done cycle.
- done  output  1  one-cycle pulse when results are valid.
- data_out  output  DATA_WIDTH  extracted (corrected) data, LSB-first.
- num_of_errors  output  2  0 = clean, 1 = single error, 2 = double error.

## Operation
- Codeword layout, W = 8/16/32:
  - Index i in 0..W-2 is Hamming position p = i+1.
  - Parity bits sit at the power-of-two positions below W.
  - cw[W-1] is the overall even-parity bit.
  - Data bits are the remaining positions in ascending order. This gives 4, 11 and 26 data bits for W = 8, 16 and 32.
- Decode rule, with s = XOR of p over all set bits in 0..W-2 and q = XOR of all W bits:
  - s=0, q=0: no error, errors = 0.
  - q=1: single error, errors = 1. If s=0, the overall bit is in error and data is unchanged. Otherwise flip index s-1 before extraction.
  - s≠0, q=0: double error, errors = 2. Data is extracted uncorrected.
- FSM states: IDLE, SCAN, CORRECT, DONE.
  - IDLE → SCAN on start. Latch codeword_in and cw_width (as W), clear s, q and the index counter.
  - SCAN: one bit per cycle, index 0..W-1, update s and q. Leave for CORRECT after index W-1.
  - CORRECT: apply the flip and extract data.
  - DONE: register data_out and num_of_errors, pulse done, return to IDLE.
- start is ignored while busy. There is no queueing.
- Input changes after the start-sample edge have no effect.
- data_out and num_of_errors hold their values until the next DONE.

## Timing
- Reset values: busy=0, done=0, data_out=0, num_of_errors=0, state IDLE, counters 0.
- Edge E0 samples start. busy is high from E0 until the edge that leaves DONE.
- done is high during the cycle following edge E(W+1): 9, 17 or 33 edges after E0. Outputs update on that same edge.
- start may be re-asserted in the cycle after done falls. It is accepted on that edge, so there are no idle gaps between back-to-back operations.
- Reset mid-operation aborts the operation: no done pulse, and outputs return to reset values.
- Counter wrap: the index counter is 5 bits and is compared against W-1; it never wraps past the latched width.

## Configuration
- ECC_DEC_CORRECT_EN defined: full SECDED behaviour as above.
- ECC_DEC_CORRECT_EN undefined: detect-only. The CORRECT state performs no flip, so data is always extracted uncorrected. num_of_errors and latency are unchanged.

## Structure
- Package ecc_pkg holds:
  - Width-code constants (CW_8, CW_16, CW_32).
  - The FSM state enum.
  - Width lookup (code → W).
  - Data-bit-count constants.
- One sub-module, ecc_data_extract: combinational packing of non-parity positions for a given width into an LSB-first data word. It is reused later by the encoder-side checker.

## Test plan
- Clean: width 00, codeword 0x55, start → done 9 edges after E0; data_out=0xB, num_of_errors=0.
- Single error: width 00, codeword 0x45 (index 4 flipped) → data_out=0xB, num_of_errors=1. With ECC_DEC_CORRECT_EN undefined → data_out=0x9, num_of_errors=1.
- Overall-bit error: width 00, codeword 0xD5 → data_out=0xB, num_of_errors=1.
- Double error: width 00, codeword 0x44 (indices 0 and 4 flipped) → data_out=0x9, num_of_errors=2.
- Width 10 with code 11, all-zero codeword, start pulsed again at E5 → the second start is ignored; a single done at E33 with data_out=0, errors=0.
- Reset at E4 of an operation → no done; busy=0, data_out=0. A following start completes normally.
